descrambler_lock_monitor: RTL
=============================

// Module: descrambler_lock_monitor
// PURPOSE
// - Per-lane receive-side additive descrambler with lock acquisition and loss detection.
// - Sits between the lane deserialiser input and the RX logical layer. It is the far end of the TX lane scrambler.
// - Reloads the shared SEED on descr_rst and descrambles the serial stream.
// - During training (all-zero payload) it verifies alignment and reports lock, errors and loss of lock.
// PARAMETERS
// - SEED      23'h1F_EEDD  LFSR reload value; must equal the TX scrambler SEED.
// - LOCK_CNT  64           consecutive zero descrambled bits needed to declare lock (2..255).
// - WIN_LEN   128          error observation window, in checked bits, while LOCKED (2..255).
// - ERR_THR   4            errors within one window that force loss of lock (1..WIN_LEN).
// PORTS
// - clk           in   1   lane bit clock; all logic on the rising edge.
// - rst           in   1   asynchronous active-low reset.
// - scrambled_in  in   1   received scrambled serial bit.
// - enable        in   1   scrambled_in is valid this cycle; LFSR advances only when high.
// - descr_rst     in   1   synchronous LFSR reload to SEED; aligns with the TX scr_rst point.
// - train_mode    in   1   expected descrambled payload is all-zero; enables checking.
// - data_out      out  1   descrambled bit, registered.
// - enable_deser  out  1   data_out valid, registered copy of the accepted enable.
// - locked        out  1   lock status level.
// - lock_lost     out  1   one-cycle pulse on the LOCKED->UNLOCKED transition.
// - err_total     out  16  saturating error count; see CONFIGURATION.
// BEHAVIOUR
// - Reset (rst=0, async):
//   - lfsr=SEED; state=UNLOCKED.
//   - All outputs 0; all counters 0.
// - LFSR: 23-bit Fibonacci, G(x)=x^23+x^21+x^16+x^8+x^5+x^2+1.
//   - key=lfsr[22]; fb=lfsr[22]^lfsr[20]^lfsr[15]^lfsr[7]^lfsr[4]^lfsr[1].
//   - Next lfsr={lfsr[21:0],fb}.
// - Accepted cycle: enable=1 and descr_rst=0.
//   - data_out<=scrambled_in^key; LFSR advances; enable_deser<=1.
//   - Latency: 1 clk from input to data_out.
// - Non-accepted cycle: enable_deser<=0; data_out and LFSR hold.
// - descr_rst=1: lfsr<=SEED; bit discarded even if enable=1; enable_deser<=0.
//   - State->CHECKING with zero_cnt=0 and win/err cleared, from any state.
//   - If the state was LOCKED, lock_lost does not pulse.
// - Check bit: descrambled bit of an accepted cycle with train_mode=1. When train_mode=0 the check counters hold.
// - States:
//   - UNLOCKED: waits for descr_rst; locked=0.
//   - CHECKING: a check bit of 0 increments zero_cnt; a 1 clears it.
//     - When zero_cnt reaches LOCK_CNT: ->LOCKED; locked=1 on the following edge.
//   - LOCKED: each check bit increments win_cnt; a 1 also increments err_cnt.
//     - err_cnt reaching ERR_THR: ->UNLOCKED; locked<=0; lock_lost pulses 1 cycle; counters clear.
//     - Otherwise, when win_cnt reaches WIN_LEN: win_cnt and err_cnt clear.
//     - Error on the last bit of a window: the threshold test uses the updated count before the window clears.
// - Counters are 8-bit. LOCK_CNT, WIN_LEN and ERR_THR are fixed at elaboration.
// CONFIGURATION
// - DESCR_ERR_CNT_EN defined:
//   - err_total increments on every check bit equal to 1, in any state except UNLOCKED.
//   - Saturates at 16'hFFFF; cleared only by rst.
// - DESCR_ERR_CNT_EN undefined: err_total is tied to 16'h0 and no counter logic is built.
// TESTING
// - Loopback: TX scrambler (same SEED, data 0) -> this block, descr_rst with scr_rst, train_mode=1.
//   -> data_out all 0; locked=1 one clk after the 64th accepted bit.
// - Inject 3 bit flips within one 128-bit window while LOCKED.
//   -> locked stays 1; with DESCR_ERR_CNT_EN, err_total=3.
// - Inject 4 flips within one window. -> lock_lost pulses once; locked=0; state UNLOCKED.
// - Toggle enable every other cycle in loopback. -> enable_deser mirrors enable delayed 1 clk; lock still acquired.
// - Assert descr_rst and enable together while LOCKED. -> no lock_lost; enable_deser=0; re-lock after 64 zeros.
// - Assert rst low mid-CHECKING. -> all outputs 0 immediately; lfsr=SEED; no lock until the next descr_rst.

Source files
------------

// File: rtl/descrambler_lock_monitor.sv
// Per-lane additive descrambler (x^23+x^21+x^16+x^8+x^5+x^2+1) with training lock monitor.
// Optional saturating error counter on err_total is built only when DESCR_ERR_CNT_EN is defined.
module descrambler_lock_monitor #(
   parameter logic [22:0] SEED     = 23'h1F_EEDD,
   parameter int unsigned LOCK_CNT = 64,
   parameter int unsigned WIN_LEN  = 128,
   parameter int unsigned ERR_THR  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scrambled_in,
   input  logic        enable,
   input  logic        descr_rst,
   input  logic        train_mode,
   output logic        data_out,
   output logic        enable_deser,
   output logic        locked,
   output logic        lock_lost,
   output logic [15:0] err_total
);

   localparam logic [7:0] LOCK_CNT8 = LOCK_CNT[7:0];
   localparam logic [7:0] WIN_LEN8  = WIN_LEN[7:0];
   localparam logic [7:0] ERR_THR8  = ERR_THR[7:0];

   typedef enum logic [1:0] {StUnlocked, StChecking, StLocked} state_e;

   state_e      state;
   logic [22:0] lfsr;
   logic [7:0]  zero_cnt;
   logic [7:0]  win_cnt;
   logic [7:0]  err_cnt;

   logic       fb;
   logic       accept;
   logic       check_bit;
   logic       check_en;
   logic [7:0] zero_nxt;
   logic [7:0] win_nxt;
   logic [7:0] err_nxt;

   always_comb begin
      fb        = lfsr[22] ^ lfsr[20] ^ lfsr[15] ^ lfsr[7] ^ lfsr[4] ^ lfsr[1];
      accept    = enable & ~descr_rst;
      check_bit = scrambled_in ^ lfsr[22];
      check_en  = accept & train_mode;
      zero_nxt  = zero_cnt + 8'd1;
      win_nxt   = win_cnt + 8'd1;
      err_nxt   = err_cnt + {7'd0, check_bit};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr         <= SEED;
         state        <= StUnlocked;
         zero_cnt     <= 8'd0;
         win_cnt      <= 8'd0;
         err_cnt      <= 8'd0;
         data_out     <= 1'b0;
         enable_deser <= 1'b0;
         locked       <= 1'b0;
         lock_lost    <= 1'b0;
      end else begin
         lock_lost    <= 1'b0;
         enable_deser <= accept;
         if (descr_rst) begin
            // Realignment restarts acquisition silently, even from LOCKED.
            lfsr     <= SEED;
            state    <= StChecking;
            zero_cnt <= 8'd0;
            win_cnt  <= 8'd0;
            err_cnt  <= 8'd0;
            locked   <= 1'b0;
         end else begin
            if (accept) begin
               data_out <= check_bit;
               lfsr     <= {lfsr[21:0], fb};
            end
            if (check_en) begin
               case (state)
                  StChecking: begin
                     if (check_bit) begin
                        zero_cnt <= 8'd0;
                     end else if (zero_nxt == LOCK_CNT8) begin
                        state    <= StLocked;
                        locked   <= 1'b1;
                        zero_cnt <= 8'd0;
                        win_cnt  <= 8'd0;
                        err_cnt  <= 8'd0;
                     end else begin
                        zero_cnt <= zero_nxt;
                     end
                  end
                  StLocked: begin
                     // Threshold is tested before the window wrap so a last-bit error counts.
                     if (err_nxt >= ERR_THR8) begin
                        state     <= StUnlocked;
                        locked    <= 1'b0;
                        lock_lost <= 1'b1;
                        win_cnt   <= 8'd0;
                        err_cnt   <= 8'd0;
                     end else if (win_nxt == WIN_LEN8) begin
                        win_cnt <= 8'd0;
                        err_cnt <= 8'd0;
                     end else begin
                        win_cnt <= win_nxt;
                        err_cnt <= err_nxt;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef DESCR_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_total <= 16'h0;
      end else if (check_en && check_bit && (state != StUnlocked) && (err_total != 16'hFFFF)) begin
         err_total <= err_total + 16'd1;
      end
   end
`else
   assign err_total = 16'h0;
`endif

endmodule
